uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/uart_rx.sv | 202 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: receiver FSM state encoding and
// the oversampling ratio used by both the receiver and the baud-rate generator.
// Optional build macro: UART_RX_PARITY_EN adds the PARITY state.
package uart_pkg;

  // Ticks per bit period delivered by the baud-rate generator.
  localparam int OVERSAMPLE = 16;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } rx_state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } rx_state_e;
`endif

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit. Both flops reset to
// RESET_VAL so the synchronized output is defined from the first clock.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling: detects the start bit, samples each
// data bit at its centre, checks the stop bit and reports the word with a
// one-cycle o_rx_done pulse.
// Optional build macro: UART_RX_PARITY_EN adds an even-parity bit after the
// data bits and the o_parity_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_tick,
  input  logic            i_rx,
  output logic [DBIT-1:0] o_dout,
  output logic            o_rx_done,
  output logic            o_frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic            o_parity_err
`endif
);

  // Bit counter spans 0..DBIT-1; the tick counter is 4 bits unless a longer
  // stop period (1.5 or 2 stop bits) needs more range to avoid wrapping.
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;

  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  rx_state_e       state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
  logic            rx_s;

`ifdef UART_RX_PARITY_EN
  logic            pbit_q, pbit_d;
  logic            perr_q, perr_d;

  // Even parity over the data word: 1 when the word holds an odd number of ones.
  function automatic logic data_parity(input logic [DBIT-1:0] v);
    return ^v;
  endfunction
`endif

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync_rx (
    .clk_i (i_clk),
    .rst_ni(i_reset_n),
    .d_i   (i_rx),
    .q_o   (rx_s)
  );

  // Next-state and datapath decisions; counters only move on ticks, while
  // entering a new state always clears the tick counter.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
    pbit_d  = pbit_q;
    perr_d  = perr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          s_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (i_tick) begin
          if (s_q == S_MID) begin
            s_d = '0;
            if (!rx_s) begin
              state_d = S_DATA;
              n_d     = '0;
            end else begin
              // Line went back high before mid start bit: a glitch.
              state_d = S_IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end else begin
          s_d = s_q;
        end
      end
      S_DATA: begin
        if (i_tick) begin
          if (s_q == S_LAST) begin
            s_d = '0;
            b_d = {rx_s, b_q[DBIT-1:1]};
            if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end else begin
          s_d = s_q;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (i_tick) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            pbit_d  = rx_s ^ data_parity(b_q);
            state_d = S_STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end else begin
          s_d = s_q;
        end
      end
`endif
      S_STOP: begin
        if (i_tick) begin
          if (s_q == S_STOP_LAST) begin
            s_d     = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
            dout_d  = b_q;
            ferr_d  = ~rx_s;
`ifdef UART_RX_PARITY_EN
            perr_d  = pbit_q;
`endif
          end else begin
            s_d = s_q + SW'(1);
          end
        end else begin
          s_d = s_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        s_d     = '0;
        n_d     = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbit_q  <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      pbit_q  <= pbit_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign o_dout      = dout_q;
  assign o_rx_done   = done_q;
  assign o_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = perr_q;
`endif

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized frames,
// checked every cycle against a frame-level reference model (queue of words
// the line carried). Honours UART_RX_PARITY_EN when defined.
module tb_uart_rx;

  localparam int DBIT   = 8;
  localparam int BITCYC = 64;  // 16 ticks per bit, one tick every 4 cycles

  logic            clk;
  logic            i_reset_n;
  logic            i_tick;
  logic            i_rx;
  logic [DBIT-1:0] o_dout;
  logic            o_rx_done;
  logic            o_frame_err;
`ifdef UART_RX_PARITY_EN
  logic            o_parity_err;
`endif

  uart_rx #(.DBIT(DBIT), .SB_TICK(16)) dut (
    .i_clk      (clk),
    .i_reset_n  (i_reset_n),
    .i_tick     (i_tick),
    .i_rx       (i_rx),
    .o_dout     (o_dout),
    .o_rx_done  (o_rx_done),
    .o_frame_err(o_frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .o_parity_err(o_parity_err)
`endif
  );

  typedef struct {
    logic [7:0] d;
    logic       ferr;
    logic       perr;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_dout;
  logic       m_ferr;
  logic       m_perr;
  int         n_cmp;
  int         n_mis;
  int         done_cnt;
  int         tcnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud tick: high one cycle out of every four.
  initial begin
    i_tick = 1'b0;
    tcnt   = 0;
    forever begin
      @(negedge clk);
      tcnt   = tcnt + 1;
      i_tick = ((tcnt % 4) == 0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp = n_cmp + 1;
    if (act !== expv) begin
      n_mis = n_mis + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Compare process: every cycle, outputs must either hold the last reported
  // word or present the next frame the line carried.
  initial begin
    logic rst_seen;
    exp_t e;
    m_dout = 8'h00;
    m_ferr = 1'b0;
    m_perr = 1'b0;
    forever begin
      @(posedge clk);
      rst_seen = !i_reset_n;
      #1;
      if (rst_seen) begin
        exp_q.delete();
        m_dout = 8'h00;
        m_ferr = 1'b0;
        m_perr = 1'b0;
      end
      if (o_rx_done === 1'b1) begin
        done_cnt = done_cnt + 1;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(o_rx_done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("done_dout", 32'(o_dout), 32'(e.d));
          chk("done_frame_err", 32'(o_frame_err), 32'(e.ferr));
`ifdef UART_RX_PARITY_EN
          chk("done_parity_err", 32'(o_parity_err), 32'(e.perr));
`endif
          m_dout = e.d;
          m_ferr = e.ferr;
          m_perr = e.perr;
        end
      end else begin
        chk("done_level", 32'(o_rx_done), 32'd0);
        chk("hold_dout", 32'(o_dout), 32'(m_dout));
        chk("hold_frame_err", 32'(o_frame_err), 32'(m_ferr));
`ifdef UART_RX_PARITY_EN
        chk("hold_parity_err", 32'(o_parity_err), 32'(m_perr));
`endif
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_reset_n = 1'b0;
    i_rx      = 1'b1;
    wait_cyc(3);
    i_reset_n = 1'b1;
  endtask

  // Drive one frame; abort_bit >= 0 resets the block mid-way through that data bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_ok,
                            input logic pbit, input int abort_bit);
    exp_t e;
    e.d    = d;
    e.ferr = !stop_ok;
    e.perr = pbit ^ (^d);
    if (abort_bit < 0) exp_q.push_back(e);
    i_rx = 1'b0;
    wait_cyc(BITCYC);
    for (int i = 0; i < DBIT; i++) begin
      i_rx = d[i];
      if (i == abort_bit) begin
        wait_cyc(BITCYC / 2);
        do_reset();
        return;
      end
      wait_cyc(BITCYC);
    end
`ifdef UART_RX_PARITY_EN
    i_rx = pbit;
    wait_cyc(BITCYC);
`endif
    if (stop_ok) begin
      i_rx = 1'b1;
      wait_cyc(BITCYC);
    end else begin
      // Low past the stop-bit centre, then back high so no new start is seen.
      i_rx = 1'b0;
      wait_cyc(48);
      i_rx = 1'b1;
      wait_cyc(16);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(negedge clk);
      k = k + 1;
    end
    chk("drain_pending_frames", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int   base;
    logic prev_ok;
    logic [7:0] rd;
    logic rs;
    n_cmp     = 0;
    n_mis     = 0;
    done_cnt  = 0;
    i_reset_n = 1'b0;
    i_rx      = 1'b1;
    wait_cyc(4);
    chk("reset_dout", 32'(o_dout), 32'h0);
    chk("reset_done", 32'(o_rx_done), 32'h0);
    chk("reset_frame_err", 32'(o_frame_err), 32'h0);
`ifdef UART_RX_PARITY_EN
    chk("reset_parity_err", 32'(o_parity_err), 32'h0);
`endif
    i_reset_n = 1'b1;
    wait_cyc(100);

    // Good frame 0xA5.
    base = done_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, -1);
    drain();
    chk("a5_pulses", 32'(done_cnt - base), 32'd1);
    chk("a5_dout", 32'(o_dout), 32'hA5);
    chk("a5_frame_err", 32'(o_frame_err), 32'h0);

    // Short low glitch: four ticks low, then high.
    base = done_cnt;
    i_rx = 1'b0;
    wait_cyc(16);
    i_rx = 1'b1;
    wait_cyc(300);
    chk("glitch_pulses", 32'(done_cnt - base), 32'd0);
    chk("glitch_dout", 32'(o_dout), 32'hA5);

    // Bad stop bit, then a good 0x00 clears the flag.
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    drain();
    chk("3c_dout", 32'(o_dout), 32'h3C);
    chk("3c_frame_err", 32'(o_frame_err), 32'h1);
    wait_cyc(BITCYC);
    send_frame(8'h00, 1'b1, 1'b0, -1);
    drain();
    chk("00_dout", 32'(o_dout), 32'h00);
    chk("00_frame_err", 32'(o_frame_err), 32'h0);

    // Reset during data bit 3 of 0xFF after a nonzero word.
    send_frame(8'h5A, 1'b1, 1'b0, -1);
    drain();
    base = done_cnt;
    send_frame(8'hFF, 1'b1, 1'b0, 3);
    wait_cyc(BITCYC * 8);
    chk("abort_pulses", 32'(done_cnt - base), 32'd0);
    chk("abort_dout", 32'(o_dout), 32'h00);
    chk("abort_frame_err", 32'(o_frame_err), 32'h0);
    send_frame(8'h81, 1'b1, 1'b0, -1);
    drain();
    chk("81_dout", 32'(o_dout), 32'h81);

    // Back-to-back frames with no idle gap.
    wait_cyc(BITCYC);
    base = done_cnt;
    send_frame(8'h12, 1'b1, 1'b0, -1);
    send_frame(8'h34, 1'b1, 1'b0, -1);
    send_frame(8'h56, 1'b1, 1'b0, -1);
    drain();
    chk("b2b_pulses", 32'(done_cnt - base), 32'd3);
    chk("b2b_last_dout", 32'(o_dout), 32'h56);

`ifdef UART_RX_PARITY_EN
    wait_cyc(BITCYC);
    send_frame(8'h07, 1'b1, 1'b0, -1);
    drain();
    chk("par0_parity_err", 32'(o_parity_err), 32'h1);
    send_frame(8'h07, 1'b1, 1'b1, -1);
    drain();
    chk("par1_parity_err", 32'(o_parity_err), 32'h0);
`endif

    // Randomized frames: random data, occasional bad stop bits, random gaps.
    wait_cyc(BITCYC);
    prev_ok = 1'b1;
    base    = done_cnt;
    for (int f = 0; f < 20; f++) begin
      rd = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 4) != 0);
      if (!prev_ok) begin
        wait_cyc(BITCYC * (1 + int'($urandom_range(0, 2))));
      end else begin
        wait_cyc(BITCYC * int'($urandom_range(0, 2)) + int'($urandom_range(0, 7)));
      end
      send_frame(rd, rs, 1'($urandom_range(0, 1)), -1);
      prev_ok = rs;
    end
    drain();
    chk("random_pulses", 32'(done_cnt - base), 32'd20);

    wait_cyc(20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_uart_rx
